// File: rtl/dr_tx_sync_to_async.sv
// dr_tx_sync_to_async: clocked 4-phase return-to-zero injector into a dual-rail pipeline.
// Define DR_TX_TIMEOUT_EN to build the sticky handshake watchdog (err_timeout).
module dr_tx_sync_to_async #(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic [2*WIDTH-1:0] dr_data,
  input  logic               dr_ack,
  output logic [15:0]        tx_count,
  output logic               err_timeout
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    DATA,
    RTZ
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [STAGES-1:0]  ack_sync;
  logic               ack_s;
  logic [2*WIDTH-1:0] data_d;
  logic               tx_inc;

  function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] word);
    logic [2*WIDTH-1:0] rails;
    rails = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rails[2*i +: 2] = word[i] ? 2'b10 : 2'b01;
    end
    return rails;
  endfunction

  // Synchronizer presets to 1 so ack reads high until a genuine low is sampled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync <= '1;
    end else begin
      ack_sync <= {ack_sync[STAGES-2:0], dr_ack};
    end
  end

  assign ack_s = ack_sync[STAGES-1];

  // Ready is withheld while ack_s is high so an IDLE->WAIT_LOW exit never drops a word
  assign in_ready = (state_q == IDLE) && !ack_s;

  always_comb begin
    state_d = state_q;
    data_d  = dr_data;
    tx_inc  = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        data_d = '0;
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (ack_s) begin
          state_d = WAIT_LOW;
        end else if (in_valid) begin
          state_d = DATA;
          data_d  = encode(in_data);
        end
      end
      DATA: begin
        if (ack_s) begin
          state_d = RTZ;
          data_d  = '0;
        end
      end
      RTZ: begin
        if (!ack_s) begin
          state_d = IDLE;
          tx_inc  = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOW;
        data_d  = '0;
      end
    endcase
  end

  // All rails switch on one edge; reset forces the spacer without waiting for clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_LOW;
      dr_data  <= '0;
      tx_count <= '0;
    end else begin
      state_q <= state_d;
      dr_data <= data_d;
      if (tx_inc) begin
        tx_count <= tx_count + 16'd1;
      end
    end
  end

`ifdef DR_TX_TIMEOUT_EN
  logic [31:0] wd_q;
  logic [31:0] wd_d;
  logic        err_q;
  logic        waiting;

  assign waiting = (state_q == DATA) || (state_q == RTZ);

  // Restarts on each entry to DATA or RTZ and saturates at the limit; FSM is never aborted
  always_comb begin
    wd_d = wd_q;
    if ((state_d != state_q) && ((state_d == DATA) || (state_d == RTZ))) begin
      wd_d = '0;
    end else if (waiting && (wd_q != 32'(TIMEOUT_CYCLES))) begin
      wd_d = wd_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_d == 32'(TIMEOUT_CYCLES)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_q;
`else
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end

  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dr_tx_sync_to_async.sv
// Scoreboard bench for dr_tx_sync_to_async: random words, 4-phase downstream model, monitor.
// Watchdog expectations follow DR_TX_TIMEOUT_EN (limit 16 when defined).
module tb_dr_tx_sync_to_async;

  localparam int WIDTH       = 4;
  localparam int SYNC_STAGES = 2;
`ifdef DR_TX_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 16;
  localparam logic ERR_EXPECTED = 1'b1;
`else
  localparam int TIMEOUT_CYCLES = 1024;
  localparam logic ERR_EXPECTED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_data;
  logic [7:0]   dr_data;
  wire          dr_ack;
  logic [15:0]  tx_count;
  logic         err_timeout;

  logic         model_en;
  logic         model_ack;
  logic         ack_manual;
  int           ack_min;
  int           ack_max;
  int           checks = 0;
  int           fails = 0;
  logic [3:0]   exp_q[$];
  int           expected_count;

  assign dr_ack = model_en ? model_ack : ack_manual;

  always #5 clk = ~clk;

  dr_tx_sync_to_async #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .dr_data    (dr_data),
    .dr_ack     (dr_ack),
    .tx_count   (tx_count),
    .err_timeout(err_timeout)
  );

  // Reference dual-rail value: each bit contributes 2 (true rail) or 1 (false rail) times 4^i
  function automatic logic [7:0] refCode(input logic [3:0] word);
    int value;
    value = 0;
    for (int i = 0; i < WIDTH; i++) begin
      value += ((int'(word) >> i) % 2 == 1) ? 2 * (4 ** i) : 4 ** i;
    end
    return 8'(value);
  endfunction

  function automatic bit allPairsValid(input logic [7:0] rails);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (rails[2*i +: 2] == 2'b00) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitReady(input int limit, input string name);
    int n;
    n = 0;
    while (!in_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(in_ready), 32'd1);
  endtask

  task automatic waitSpacer(input int limit, input string name);
    int n;
    n = 0;
    while (dr_data != 8'h00 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(dr_data), 32'h00);
  endtask

  // Called at a negedge; pushes the word at acceptance and checks one-cycle latency
  task automatic applyStimulus(input logic [3:0] word, input logic [7:0] code, input bit hold);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = word;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 300 cycles");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(word);
    @(negedge clk);
    checkOutput("codeword_latency", 32'(dr_data), 32'(code));
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic doReset(input logic ack_level);
    @(negedge clk);
    model_en   = 1'b0;
    ack_manual = ack_level;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Downstream stage model: ack rises after a complete codeword, falls after the spacer
  initial begin : ack_model
    int dly;
    dly = -1;
    model_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!model_en || rst) begin
        model_ack = 1'b0;
        dly = -1;
      end else if (!model_ack && allPairsValid(dr_data)) begin
        if (dly < 0) dly = $urandom_range(ack_max, ack_min);
        if (dly == 0) begin
          model_ack = 1'b1;
          dly = -1;
        end else begin
          dly--;
        end
      end else if (model_ack && dr_data == 8'h00) begin
        if (dly < 0) dly = $urandom_range(ack_max, ack_min);
        if (dly == 0) begin
          model_ack = 1'b0;
          dly = -1;
        end else begin
          dly--;
        end
      end
    end
  end

  // Monitor: each new codeword is matched against the scoreboard queue
  initial begin : monitor
    logic [7:0] prev;
    logic [3:0] word;
    bit         has11;
    prev = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 8'h00;
      end else begin
        has11 = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          if (dr_data[2*i +: 2] == 2'b11) has11 = 1'b1;
        end
        checkOutput("no_rail_pair_11", 32'(has11), 32'd0);
        if (dr_data != 8'h00 && prev == 8'h00) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_codeword: got 0x%0h, expected no codeword", dr_data);
          end else begin
            word = exp_q.pop_front();
            checkOutput("scoreboard_word", 32'(dr_data), 32'(refCode(word)));
          end
        end else if (dr_data != 8'h00 && dr_data != prev) begin
          checks++;
          fails++;
          $display("[TB] FAIL spacer_between_codewords: got 0x%0h after 0x%0h, expected 0x00 between", dr_data, prev);
        end
        prev = dr_data;
      end
    end
  end

  initial begin : main
    bit         stuck;
    logic [3:0] word;
    bit         hold;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 4'h0;
    model_en   = 1'b0;
    ack_manual = 1'b1;
    ack_min    = 0;
    ack_max    = 7;

    // Reset values, then release with ack high: ready must stay low
    repeat (3) @(negedge clk);
    checkOutput("reset_dr_data", 32'(dr_data), 32'h00);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_tx_count", 32'(tx_count), 32'd0);
    checkOutput("reset_err_timeout", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    stuck = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (in_ready) stuck = 1'b1;
    end
    checkOutput("ready_low_while_ack_high", 32'(stuck), 32'd0);
    ack_manual = 1'b0;
    waitReady(SYNC_STAGES + 2, "ready_after_ack_falls");

    doReset(1'b0);
    waitReady(SYNC_STAGES + 2, "ready_after_release_ack_low");

    // Single word with a fixed three-cycle ack delay
    model_en = 1'b1;
    ack_min  = 3;
    ack_max  = 3;
    applyStimulus(4'hA, 8'h99, 1'b0);
    waitSpacer(30, "spacer_after_ack");
    waitReady(30, "ready_after_single");
    checkOutput("tx_count_single", 32'(tx_count), 32'd1);

    // Encoding table
    ack_min = 0;
    ack_max = 7;
    applyStimulus(4'h0, 8'h55, 1'b0);
    waitReady(60, "ready_after_0");
    applyStimulus(4'hF, 8'hAA, 1'b0);
    waitReady(60, "ready_after_F");
    applyStimulus(4'h6, 8'h69, 1'b0);
    waitReady(60, "ready_after_6");
    checkOutput("tx_count_encoding", 32'(tx_count), 32'd4);

    // Back-to-back with in_valid held high
    doReset(1'b0);
    waitReady(SYNC_STAGES + 2, "ready_before_b2b");
    model_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(4'(i), refCode(4'(i)), 1'b1);
    end
    in_valid = 1'b0;
    waitReady(60, "ready_after_b2b");
    checkOutput("tx_count_b2b", 32'(tx_count), 32'd4);

    // Random words, random gaps and holds
    expected_count = 4;
    for (int i = 0; i < 25; i++) begin
      word = 4'($urandom_range(15, 0));
      hold = 1'($urandom_range(1, 0));
      applyStimulus(word, refCode(word), hold);
      expected_count++;
      if (!hold) repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    in_valid = 1'b0;
    waitReady(60, "ready_after_random");
    checkOutput("tx_count_random", 32'(tx_count), 32'(expected_count));
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of DATA
    model_en   = 1'b0;
    ack_manual = 1'b0;
    applyStimulus(4'hA, 8'h99, 1'b0);
    @(negedge clk);
    #2;
    rst        = 1'b1;
    ack_manual = 1'b1;
    #1;
    checkOutput("async_reset_spacer", 32'(dr_data), 32'h00);
    checkOutput("async_reset_tx_count", 32'(tx_count), 32'd0);
    checkOutput("async_reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stuck = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (in_ready) stuck = 1'b1;
    end
    checkOutput("restart_waits_ack_low", 32'(stuck), 32'd0);
    ack_manual = 1'b0;
    waitReady(SYNC_STAGES + 2, "restart_ready");
    model_en = 1'b1;
    applyStimulus(4'h3, refCode(4'h3), 1'b0);
    waitReady(60, "ready_after_restart_word");
    checkOutput("tx_count_after_restart", 32'(tx_count), 32'd1);

    // Watchdog: hold ack low after a codeword, then complete late
    model_en   = 1'b0;
    ack_manual = 1'b0;
    applyStimulus(4'h5, refCode(4'h5), 1'b0);
`ifdef DR_TX_TIMEOUT_EN
    repeat (15) @(negedge clk);
    checkOutput("err_before_limit", 32'(err_timeout), 32'd0);
    @(negedge clk);
    checkOutput("err_at_limit", 32'(err_timeout), 32'd1);
`else
    repeat (40) @(negedge clk);
    checkOutput("err_disabled_stays_low", 32'(err_timeout), 32'd0);
`endif
    checkOutput("codeword_held_without_ack", 32'(dr_data), 32'(refCode(4'h5)));
    ack_manual = 1'b1;
    waitSpacer(30, "late_ack_spacer");
    ack_manual = 1'b0;
    waitReady(30, "late_ack_ready");
    checkOutput("tx_count_late_ack", 32'(tx_count), 32'd2);
    checkOutput("err_after_late_ack", 32'(err_timeout), 32'(ERR_EXPECTED));
    checkOutput("scoreboard_final", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : global_timeout
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 500000 time units");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
